// File: rtl/hotspot_overlay_mc.sv
// Multi-channel hotspot sprite overlay for an RGB565 video stream.
// Three-stage pipeline: hit test/ROM address, ROM read, composite.
module hotspot_overlay_mc #(
  parameter int N_CH        = 4,
  parameter int SIZE        = 49,
  parameter int H_RES       = 480,
  parameter int V_RES       = 272,
  parameter int HOLD_FRAMES = 30,
  parameter int ADDR_W      = 12
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              pos_we,
  input  logic [2:0]        pos_ch,
  input  logic [31:0]       pos_x,
  input  logic [31:0]       pos_y,
  input  logic              blend_mode,
  input  logic              in_vs,
  input  logic              in_hs,
  input  logic              in_de,
  input  logic [15:0]       in_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              out_vs,
  output logic              out_hs,
  output logic              out_de,
  output logic [15:0]       out_rgb,
  output logic [N_CH-1:0]   active_mask
);

  localparam int RADIUS = (SIZE - 1) / 2;
  localparam int CW     = 12;

  logic [CW-1:0]     x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [CW-1:0]     sh_x_q [N_CH];
  logic [CW-1:0]     sh_x_d [N_CH];
  logic [CW-1:0]     sh_y_q [N_CH];
  logic [CW-1:0]     sh_y_d [N_CH];
  logic [CW-1:0]     act_x_q [N_CH];
  logic [CW-1:0]     act_x_d [N_CH];
  logic [CW-1:0]     act_y_q [N_CH];
  logic [CW-1:0]     act_y_d [N_CH];
  logic [7:0]        life_q [N_CH];
  logic [7:0]        life_d [N_CH];
  logic [N_CH-1:0]   pend_q, pend_d, mask_q, mask_d;

  logic              vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d, hit1_q, hit1_d;
  logic [15:0]       rgb1_q, rgb1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic              vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d, hit2_q, hit2_d;
  logic [15:0]       rgb2_q, rgb2_d;
  logic              vs3_q, vs3_d, hs3_q, hs3_d, de3_q, de3_d;
  logic [15:0]       rgb3_q, rgb3_d;

  logic              vs_rise;
  logic [CW-1:0]     wr_x, wr_y, dx12, dy12;
  logic signed [31:0] dx, dy, win_dx, win_dy, addr_s;
  logic [5:0]        r_sum, b_sum;
  logic [6:0]        g_sum;

  function automatic logic [CW-1:0] clamp(input logic [31:0] v, input int hi);
    if ($signed(v) < 0)       return '0;
    else if ($signed(v) > hi) return CW'(hi);
    else                      return v[CW-1:0];
  endfunction

  function automatic logic near(input logic signed [31:0] d);
    return (d >= -RADIUS) && (d <= RADIUS);
  endfunction

  assign vs_rise = in_vs & ~vs1_q;
  assign wr_x    = clamp(pos_x, H_RES - 1);
  assign wr_y    = clamp(pos_y, V_RES - 1);

  always_comb begin
    x_cnt_d = in_de ? x_cnt_q + CW'(1) : '0;
    y_cnt_d = y_cnt_q;
    if (vs_rise)             y_cnt_d = '0;
    else if (de1_q && !in_de) y_cnt_d = y_cnt_q + CW'(1);
  end

  // Commit is evaluated before the write so a write on the vsync edge stays pending.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sh_x_d[c]  = sh_x_q[c];
      sh_y_d[c]  = sh_y_q[c];
      act_x_d[c] = act_x_q[c];
      act_y_d[c] = act_y_q[c];
      life_d[c]  = life_q[c];
      mask_d[c]  = (life_q[c] != 8'd0);
      if (vs_rise) begin
        if (pend_q[c]) begin
          act_x_d[c] = sh_x_q[c];
          act_y_d[c] = sh_y_q[c];
          life_d[c]  = 8'(HOLD_FRAMES);
          pend_d[c]  = 1'b0;
        end else if (life_q[c] != 8'd0) begin
          life_d[c]  = life_q[c] - 8'd1;
        end
      end
      if (pos_we && pos_ch == 3'(c)) begin
        sh_x_d[c] = wr_x;
        sh_y_d[c] = wr_y;
        pend_d[c] = 1'b1;
      end
    end
  end

  always_comb begin
    hit1_d = 1'b0;
    win_dx = '0;
    win_dy = '0;
    dx12   = '0;
    dy12   = '0;
    dx     = '0;
    dy     = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      dx12 = x_cnt_q - act_x_q[c];
      dy12 = y_cnt_q - act_y_q[c];
      dx   = {{(32-CW){dx12[CW-1]}}, dx12};
      dy   = {{(32-CW){dy12[CW-1]}}, dy12};
      if (!hit1_d && in_de && life_q[c] != 8'd0 && near(dx) && near(dy)) begin
        hit1_d = 1'b1;
        win_dx = dx;
        win_dy = dy;
      end
    end
    addr_s  = (win_dy + RADIUS) * SIZE + win_dx + RADIUS;
    addr1_d = hit1_d ? ADDR_W'(addr_s) : '0;
    vs1_d   = in_vs;
    hs1_d   = in_hs;
    de1_d   = in_de;
    rgb1_d  = in_rgb;
  end

  always_comb begin
    vs2_d  = vs1_q;
    hs2_d  = hs1_q;
    de2_d  = de1_q;
    hit2_d = hit1_q;
    rgb2_d = rgb1_q;
    vs3_d  = vs2_q;
    hs3_d  = hs2_q;
    de3_d  = de2_q;
    r_sum  = {1'b0, rgb2_q[15:11]} + {1'b0, rom_data[15:11]};
    g_sum  = {1'b0, rgb2_q[10:5]}  + {1'b0, rom_data[10:5]};
    b_sum  = {1'b0, rgb2_q[4:0]}   + {1'b0, rom_data[4:0]};
    rgb3_d = '0;
    if (de2_q) begin
      if (!hit2_q || rom_data == 16'h0000) rgb3_d = rgb2_q;
      else if (blend_mode)                 rgb3_d = {r_sum[5:1], g_sum[6:1], b_sum[5:1]};
      else                                 rgb3_d = rom_data;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        sh_x_q[c]  <= '0;
        sh_y_q[c]  <= '0;
        act_x_q[c] <= '0;
        act_y_q[c] <= '0;
        life_q[c]  <= '0;
      end
      {vs1_q, hs1_q, de1_q, hit1_q} <= '0;
      rgb1_q  <= '0;
      addr1_q <= '0;
      {vs2_q, hs2_q, de2_q, hit2_q} <= '0;
      rgb2_q  <= '0;
      {vs3_q, hs3_q, de3_q} <= '0;
      rgb3_q  <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      for (int unsigned c = 0; c < N_CH; c++) begin
        sh_x_q[c]  <= sh_x_d[c];
        sh_y_q[c]  <= sh_y_d[c];
        act_x_q[c] <= act_x_d[c];
        act_y_q[c] <= act_y_d[c];
        life_q[c]  <= life_d[c];
      end
      {vs1_q, hs1_q, de1_q, hit1_q} <= {vs1_d, hs1_d, de1_d, hit1_d};
      rgb1_q  <= rgb1_d;
      addr1_q <= addr1_d;
      {vs2_q, hs2_q, de2_q, hit2_q} <= {vs2_d, hs2_d, de2_d, hit2_d};
      rgb2_q  <= rgb2_d;
      {vs3_q, hs3_q, de3_q} <= {vs3_d, hs3_d, de3_d};
      rgb3_q  <= rgb3_d;
    end
  end

  assign rom_addr    = addr1_q;
  assign out_vs      = vs3_q;
  assign out_hs      = hs3_q;
  assign out_de      = de3_q;
  assign out_rgb     = rgb3_q;
  assign active_mask = mask_q;

endmodule

// File: tb/tb_hotspot_overlay_mc.sv
// Directed bench for hotspot_overlay_mc: probe pixels with hand-computed
// ROM addresses / composited colours, plus per-frame active_mask checks.
module tb_hotspot_overlay_mc;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b0;
  logic        pos_we = 1'b0;
  logic [2:0]  pos_ch = '0;
  logic [31:0] pos_x = '0, pos_y = '0;
  logic        blend_mode = 1'b0;
  logic        in_vs = 1'b0, in_hs = 1'b0, in_de = 1'b0;
  logic [15:0] in_rgb = '0;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic        out_vs, out_hs, out_de;
  logic [15:0] out_rgb;
  logic [3:0]  active_mask;

  always #5 clk_pix = ~clk_pix;

  hotspot_overlay_mc #(
    .N_CH(4), .SIZE(49), .H_RES(480), .V_RES(272), .HOLD_FRAMES(3), .ADDR_W(12)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .pos_we(pos_we), .pos_ch(pos_ch),
    .pos_x(pos_x), .pos_y(pos_y), .blend_mode(blend_mode),
    .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de), .in_rgb(in_rgb),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_vs(out_vs), .out_hs(out_hs), .out_de(out_de), .out_rgb(out_rgb),
    .active_mask(active_mask)
  );

  int  n_chk = 0, n_bad = 0;
  bit  mon_en = 0;
  int  cam_mode = 0, rom_mode = 0;

  int   cur_x = 0, cur_y = 0, s1_x = 0, s1_y = 0, s2_x = 0, s2_y = 0, s3_x = 0, s3_y = 0;
  logic cur_vs = 0, cur_hs = 0, cur_de = 0;
  logic s1_vs = 0, s1_hs = 0, s1_de = 0, s2_vs = 0, s2_hs = 0, s2_de = 0;
  logic s3_vs = 0, s3_hs = 0, s3_de = 0;

  bit          nxt_we = 0;
  logic [2:0]  nxt_ch = '0;
  logic [31:0] nxt_x = '0, nxt_y = '0;
  bit          mid_en = 0, vsw_en = 0;
  int          mid_line = 0;
  logic [2:0]  ev_ch = '0;
  logic [31:0] ev_x = '0, ev_y = '0;

  int          px [8];
  int          py [8];
  logic [11:0] pa [8];
  logic [15:0] pr [8];
  int          pn = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cam(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x + 1);
    yb = 8'(y);
    return (cam_mode != 0) ? 16'hF800 : {xb, yb};
  endfunction

  function automatic logic [15:0] rom_fn(input logic [11:0] a);
    case (rom_mode)
      0:       return {4'h8, a};
      1:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk_pix) begin
    rom_data <= rom_fn(rom_addr);
    {s1_vs, s1_hs, s1_de, s1_x, s1_y} <= {cur_vs, cur_hs, cur_de, cur_x, cur_y};
    {s2_vs, s2_hs, s2_de, s2_x, s2_y} <= {s1_vs, s1_hs, s1_de, s1_x, s1_y};
    {s3_vs, s3_hs, s3_de, s3_x, s3_y} <= {s2_vs, s2_hs, s2_de, s2_x, s2_y};
  end

  always @(negedge clk_pix) begin
    if (mon_en) begin
      check_val("sync", {29'd0, out_vs, out_hs, out_de}, {29'd0, s3_vs, s3_hs, s3_de});
      if (!s3_de) check_val("blank", {16'd0, out_rgb}, 32'd0);
      for (int i = 0; i < pn; i++) begin
        if (s1_de && s1_x == px[i] && s1_y == py[i])
          check_val($sformatf("addr(%0d,%0d)", px[i], py[i]), {20'd0, rom_addr}, {20'd0, pa[i]});
        if (s3_de && s3_x == px[i] && s3_y == py[i])
          check_val($sformatf("rgb(%0d,%0d)", px[i], py[i]), {16'd0, out_rgb}, {16'd0, pr[i]});
      end
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic de, input int x, input int y);
    @(negedge clk_pix);
    in_vs  = vs;
    in_hs  = hs;
    in_de  = de;
    in_rgb = de ? cam(x, y) : 16'($urandom);
    pos_we = nxt_we;
    pos_ch = nxt_ch;
    pos_x  = nxt_x;
    pos_y  = nxt_y;
    nxt_we = 0;
    cur_vs = vs; cur_hs = hs; cur_de = de; cur_x = x; cur_y = y;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [31:0] x, input logic [31:0] y);
    nxt_we = 1; nxt_ch = ch; nxt_x = x; nxt_y = y;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] a, input logic [15:0] r);
    px[pn] = x; py[pn] = y; pa[pn] = a; pr[pn] = r;
    pn++;
  endtask

  task automatic frame(input int lines, input int width);
    if (vsw_en) begin
      nxt_we = 1; nxt_ch = ev_ch; nxt_x = ev_x; nxt_y = ev_y;
      vsw_en = 0;
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < width; x++) begin
        if (mid_en && y == mid_line && x == 0) begin
          nxt_we = 1; nxt_ch = ev_ch; nxt_x = ev_x; nxt_y = ev_y;
          mid_en = 0;
        end
        drive(0, 0, 1, x, y);
      end
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
    repeat (5) drive(0, 0, 0, 0, 0);
    pn = 0;
  endtask

  initial begin
    // Reset held with random video on the inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_pix);
      {in_vs, in_hs, in_de} = 3'($urandom);
      in_rgb = 16'($urandom);
      #1;
      check_val("rst_out", {1'b0, out_vs, out_hs, out_de, out_rgb, rom_addr}, 32'd0);
      check_val("rst_mask", {28'd0, active_mask}, 32'd0);
    end
    @(negedge clk_pix);
    {in_vs, in_hs, in_de} = '0;
    rst_n = 1'b1;
    repeat (4) drive(0, 0, 0, 0, 0);
    mon_en = 1;

    // No writes: pure passthrough.
    probe(5, 2, 12'd0, 16'h0602);
    probe(0, 0, 12'd0, 16'h0100);
    probe(15, 3, 12'd0, 16'h1003);
    frame(4, 16);
    check_val("mask_idle", {28'd0, active_mask}, 32'h0);

    // Single hotspot at (100,50), opaque.
    wr(0, 100, 50);
    probe(76, 26, 12'd0, 16'h8000);
    probe(124, 74, 12'd2400, 16'h8960);
    probe(75, 26, 12'd0, 16'h4C1A);
    probe(100, 50, 12'd1200, 16'h84B0);
    frame(80, 128);
    check_val("mask_single", {28'd0, active_mask}, 32'h1);

    // Clamp: (-20,300) lands at (0,271), cropped left and bottom.
    wr(1, -32'sd20, 32'd300);
    probe(0, 271, 12'd1200, 16'h84B0);
    probe(24, 271, 12'd1224, 16'h84C8);
    probe(25, 271, 12'd0, 16'h1A0F);
    probe(0, 247, 12'd24, 16'h8018);
    probe(0, 246, 12'd0, 16'h01F6);
    frame(272, 32);
    check_val("mask_clamp", {28'd0, active_mask}, 32'h3);

    // Overlap priority and out-of-range channel index.
    wr(0, 60, 40);
    wr(2, 65, 40);
    wr(5, 10, 10);
    probe(60, 40, 12'd1200, 16'h84B0);
    probe(89, 40, 12'd1224, 16'h84C8);
    probe(10, 10, 12'd0, 16'h0B0A);
    probe(36, 16, 12'd0, 16'h8000);
    frame(48, 72);
    check_val("mask_overlap", {28'd0, active_mask}, 32'h7);

    // Mid-frame write: old position kept for the rest of this frame.
    wr(0, 40, 150);
    mid_en = 1; mid_line = 120; ev_ch = 0; ev_x = 20; ev_y = 140;
    probe(40, 150, 12'd1200, 16'h84B0);
    probe(20, 140, 12'd690, 16'h82B2);
    frame(160, 64);
    check_val("mask_m1", {28'd0, active_mask}, 32'h7);

    vsw_en = 1; ev_ch = 0; ev_x = 50; ev_y = 100;
    probe(20, 140, 12'd1200, 16'h84B0);
    probe(40, 150, 12'd1710, 16'h86AE);
    probe(50, 100, 12'd0, 16'h3364);
    frame(160, 64);
    check_val("mask_m2", {28'd0, active_mask}, 32'h5);

    probe(50, 100, 12'd1200, 16'h84B0);
    probe(26, 76, 12'd0, 16'h8000);
    probe(25, 76, 12'd0, 16'h1A4C);
    frame(110, 64);
    check_val("mask_m3", {28'd0, active_mask}, 32'h1);

    // Fade: ch3 written once, ch0 refreshed every frame.
    wr(3, 5, 5);
    for (int f = 0; f < 5; f++) begin
      wr(0, 5, 5);
      frame(4, 8);
      check_val($sformatf("mask_fade%0d", f), {28'd0, active_mask}, (f < 3) ? 32'h9 : 32'h1);
    end

    // Blend / opaque / transparent compositing.
    blend_mode = 1; cam_mode = 1; rom_mode = 1;
    wr(0, 5, 5);
    probe(5, 5, 12'd1200, 16'h780F);
    probe(15, 7, 12'd1308, 16'h780F);
    frame(8, 16);
    rom_mode = 2;
    wr(0, 5, 5);
    probe(5, 5, 12'd1200, 16'hF800);
    frame(8, 16);
    blend_mode = 0; rom_mode = 1;
    wr(0, 5, 5);
    probe(5, 5, 12'd1200, 16'h001F);
    frame(8, 16);
    blend_mode = 1; cam_mode = 0; rom_mode = 0;
    wr(0, 5, 5);
    probe(5, 5, 12'd1200, 16'h454A);
    frame(8, 16);

    // Reset in the middle of an active line.
    blend_mode = 0;
    wr(0, 5, 5);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    for (int x = 0; x < 10; x++) drive(0, 0, 1, x, 0);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out", {15'd0, out_de, out_rgb}, 32'd0);
    check_val("midrst_mask", {28'd0, active_mask}, 32'd0);
    repeat (2) drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (4) drive(0, 0, 0, 0, 0);
    mon_en = 1;
    probe(5, 5, 12'd0, 16'h0605);
    frame(8, 16);
    check_val("mask_after_rst", {28'd0, active_mask}, 32'h0);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
